// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: frame state
// encodings, data width and bit-timing counter width.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS_N = 8;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4,
    BREAK      = 3'd5
  } uart_state_t;

  // Even parity of a data byte: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS_N-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, one independent flop chain
// per bit, with a configurable reset value so an idle line reads correctly
// straight out of reset.
`timescale 1ns/1ps
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      // Two-stage capture of one asynchronous bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= RST_VAL[gi];
          sync_reg <= RST_VAL[gi];
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, idle-high, sampled mid-bit at CLKS_PER_BIT
// clocks per bit. Holds one byte with a full/read handshake plus framing and
// overrun status. Define UART_RX_PARITY_EN for 8E1 frames with a parity check.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1000,
  parameter bit INVERT       = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   re,
  output logic [DATA_BITS_N-1:0] dout,
  output logic                   full,
  output logic                   valid,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_pin;
  logic rx_s;

  uart_state_t            state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [2:0]             index_reg, index_next;
  logic [DATA_BITS_N-1:0] shift_reg, shift_next;

  logic [DATA_BITS_N-1:0] dout_reg;
  logic                   full_reg;
  logic                   valid_reg;
  logic                   frame_err_reg;
  logic                   overrun_reg;

  logic load;
  logic ferr;

`ifdef UART_RX_PARITY_EN
  logic par_bit_reg, par_bit_next;
  logic perr;
  logic parity_err_reg;
`endif

  // Inversion is applied on the raw pin so the synchronizer always idles high.
  assign rx_pin = INVERT ? ~rx : rx;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (rx_s)
  );

  // Frame sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      index_reg <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      index_reg <= index_next;
      shift_reg <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= par_bit_next;
`endif
    end
  end

  // Next-state logic: bit timing, data shifting and stop-bit decision.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    index_next = index_reg;
    shift_next = shift_reg;
    load       = 1'b0;
    ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit_reg;
    perr         = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        count_next = '0;
        index_next = '0;
        if (!rx_s) state_next = START_BIT;
      end
      START_BIT: begin
        if (count_reg == HALF) begin
          count_next = '0;
          // Line back high at mid-start is a glitch: drop it silently.
          state_next = rx_s ? IDLE : DATA_BITS;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (count_reg == LAST) begin
          count_next = '0;
          shift_next = {rx_s, shift_reg[DATA_BITS_N-1:1]};
          index_next = index_reg + 3'd1;
          if (index_reg == 3'(DATA_BITS_N - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY_BIT;
`else
            state_next = STOP_BIT;
`endif
          end
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: begin
        if (count_reg == LAST) begin
          count_next   = '0;
          par_bit_next = rx_s;
          state_next   = STOP_BIT;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
`endif
      STOP_BIT: begin
        if (count_reg == LAST) begin
          count_next = '0;
`ifdef UART_RX_PARITY_EN
          perr = (par_bit_reg != even_parity(shift_reg));
`endif
          if (rx_s) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            ferr       = 1'b1;
            state_next = BREAK;
          end
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      BREAK: begin
        // A held-low line reports once, then waits here for it to recover.
        count_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        index_next = '0;
      end
    endcase
  end

  // Output holding register, status pulses and CPU read handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg      <= '0;
      full_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      valid_reg     <= load;
      frame_err_reg <= ferr;
      if (load) begin
        // A new byte always lands; a concurrent read only affects overrun.
        dout_reg <= shift_reg;
        full_reg <= 1'b1;
        if (full_reg && !re)     overrun_reg <= 1'b1;
        else if (full_reg && re) overrun_reg <= 1'b0;
      end else if (re && full_reg) begin
        full_reg    <= 1'b0;
        overrun_reg <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity result pulses alongside the stop-bit decision.
  always_ff @(posedge clk) begin
    if (rst) parity_err_reg <= 1'b0;
    else     parity_err_reg <= perr;
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign dout      = dout_reg;
  assign full      = full_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a plain and an inverted-pin receiver listen to the same
// logical line. Frames are built from bit lists, expected byte/full/overrun
// come from a small handshake model. Honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT   = 4 + HALF + 10 * CPB;
`else
  localparam int NBITS = 10;
  localparam int LAT   = 4 + HALF + 9 * CPB;
`endif

  logic       clk, rst, line, re;
  logic [7:0] dout_a, dout_b;
  logic       full_a, valid_a, ferr_a, ovr_a, perr_a;
  logic       full_b, valid_b, ferr_b, ovr_b, perr_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int v_tot = 0, vb_tot = 0, fe_tot = 0, pe_tot = 0, v_cyc = 0;
  int v0, vb0, fe0, pe0, fall_cyc;

  logic [7:0] exp_dout;
  logic       exp_full, exp_ovr;

  uart_rx #(.CLKS_PER_BIT(CPB), .INVERT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .rx(line), .re(re), .dout(dout_a), .full(full_a),
    .valid(valid_a), .frame_err(ferr_a), .overrun(ovr_a), .parity_err(perr_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .INVERT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .rx(~line), .re(re), .dout(dout_b), .full(full_b),
    .valid(valid_b), .frame_err(ferr_b), .overrun(ovr_b), .parity_err(perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters observed away from the active edge.
  always @(negedge clk) begin
    if (valid_a) begin
      v_tot = v_tot + 1;
      v_cyc = cyc;
    end
    if (valid_b) vb_tot = vb_tot + 1;
    if (ferr_a)  fe_tot = fe_tot + 1;
    if (perr_a)  pe_tot = pe_tot + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic snap();
    v0 = v_tot; vb0 = vb_tot; fe0 = fe_tot; pe0 = pe_tot;
  endtask

  // Drive one frame; re_k / rst_k choose a bit-cycle to pulse re or rst (-1 = never).
  task automatic drive_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                             input int re_k, input int rst_k);
    logic [9:0] frame;
    int pos;
    frame = {(^d) ^ par_flip, d, 1'b0};
    for (int k = 0; k < NBITS * CPB; k++) begin
      @(negedge clk);
      if (k == 0) fall_cyc = cyc;
      pos  = k / CPB;
      line = (pos == NBITS - 1) ? stop_b : frame[pos];
      re   = (k == re_k);
      rst  = (k == rst_k);
    end
    @(negedge clk);
    re  = 1'b0;
    rst = 1'b0;
  endtask

  // Handshake model: a good frame always loads; overrun when unread data is overwritten.
  task automatic model_load(input logic [7:0] d, input logic re_now);
    if (exp_full && !re_now)     exp_ovr = 1'b1;
    else if (exp_full && re_now) exp_ovr = 1'b0;
    exp_full = 1'b1;
    exp_dout = d;
  endtask

  task automatic do_read();
    @(negedge clk); re = 1'b1;
    @(negedge clk); re = 1'b0;
    if (exp_full) begin
      exp_full = 1'b0;
      exp_ovr  = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".dout"},    32'(dout_a), 32'(exp_dout));
    check({tag, ".full"},    32'(full_a), 32'(exp_full));
    check({tag, ".overrun"}, 32'(ovr_a),  32'(exp_ovr));
    check({tag, ".dout_inv"}, 32'(dout_b), 32'(exp_dout));
    check({tag, ".full_inv"}, 32'(full_b), 32'(exp_full));
  endtask

  task automatic good_frame(input string tag, input logic [7:0] d, input int re_k);
    snap();
    drive_frame(d, 1'b1, 1'b0, re_k, -1);
    idle(3);
    model_load(d, re_k >= 0);
    check({tag, ".valid_cnt"},  32'(v_tot - v0),  32'd1);
    check({tag, ".valid_inv"},  32'(vb_tot - vb0), 32'd1);
    check({tag, ".latency"},    32'(v_cyc - fall_cyc), 32'(LAT));
    check({tag, ".frame_err"},  32'(fe_tot - fe0), 32'd0);
    check({tag, ".parity_err"}, 32'(pe_tot - pe0), 32'd0);
    check_regs(tag);
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; line = 1'b1; re = 1'b0;
    exp_dout = 8'h00; exp_full = 1'b0; exp_ovr = 1'b0;
    idle(3);
    check("reset.valid", 32'(valid_a), 32'd0);
    check("reset.frame_err", 32'(ferr_a), 32'd0);
    check("reset.parity_err", 32'(perr_a), 32'd0);
    check_regs("reset");
    check("reset.state", 32'(dut_a.state_reg), 32'(IDLE));
    rst = 1'b0;
    idle(4);

    // Basic byte then read.
    good_frame("a5", 8'hA5, -1);
    do_read();
    check_regs("a5_read");

    // Start glitch shorter than half a bit.
    snap();
    @(negedge clk); line = 1'b0;
    idle(3);
    line = 1'b1;
    idle(20);
    check("glitch.valid_cnt", 32'(v_tot - v0), 32'd0);
    check("glitch.frame_err", 32'(fe_tot - fe0), 32'd0);
    check("glitch.state", 32'(dut_a.state_reg), 32'(IDLE));
    check_regs("glitch");

    // Bad stop bit with the line held low: one framing error, no byte.
    snap();
    drive_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    idle(40);
    line = 1'b1;
    idle(5);
    check("break.frame_err", 32'(fe_tot - fe0), 32'd1);
    check("break.valid_cnt", 32'(v_tot - v0), 32'd0);
    check_regs("break");
    good_frame("after_break", 8'h81, -1);
    do_read();

    // Overrun without a read, then cleared by a read.
    good_frame("ovr1", 8'h11, -1);
    good_frame("ovr2", 8'h22, -1);
    do_read();
    check_regs("ovr_read");

    // Read landing in the load cycle: the load wins, no overrun.
    good_frame("ld1", 8'h11, -1);
    good_frame("ld2", 8'h22, LAT - 1);
    do_read();

    // Reset during data bit 4 with a byte still pending.
    good_frame("pre_rst", 8'($urandom), -1);
    snap();
    drive_frame(8'hFF, 1'b1, 1'b0, -1, 5 * CPB + 2);
    idle(3);
    exp_dout = 8'h00; exp_full = 1'b0; exp_ovr = 1'b0;
    check("rst.valid_cnt", 32'(v_tot - v0), 32'd0);
    check("rst.state", 32'(dut_a.state_reg), 32'(IDLE));
    check_regs("rst");
    good_frame("post_rst", 8'h5A, -1);
    do_read();

    // Randomised bytes, gaps and reads.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      idle($urandom_range(0, 5));
      good_frame($sformatf("rnd%0d", i), d, -1);
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        check_regs($sformatf("rnd%0d_read", i));
      end
    end
    do_read();

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: error pulse, byte still delivered.
    snap();
    drive_frame(8'h07, 1'b1, 1'b1, -1, -1);
    idle(3);
    model_load(8'h07, 1'b0);
    check("par.parity_err", 32'(pe_tot - pe0), 32'd1);
    check("par.valid_cnt", 32'(v_tot - v0), 32'd1);
    check_regs("par");
    do_read();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
